tlul_to_axi4_wr: RTL and testbench
==================================

TLUL_TO_AXI4_WR -- requirements
Module: tlul_to_axi4_wr

Interface
REQ-001 SHALL have parameter DataWidth, default 64, data bus width in bits (32 or 64).
REQ-002 SHALL have parameter AddrWidth, default 32, address width in bits.
REQ-003 SHALL have parameter SourceWidth, default 8, TL source ID width.
REQ-004 SHALL have parameter Depth, default 4, maximum outstanding A requests (power of two, >=2).
REQ-005 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-007 SHALL have port tl_a_valid  input  1  A request valid.
REQ-008 SHALL have port tl_a_ready  output  1  A request accepted.
REQ-009 SHALL have port tl_a_opcode  input  3  0=PutFullData, 1=PutPartialData, 4=Get, others unsupported.
REQ-010 SHALL have port tl_a_size  input  3  log2 of access bytes.
REQ-011 SHALL have port tl_a_source  input  SourceWidth  requester ID.
REQ-012 SHALL have port tl_a_address  input  AddrWidth  byte address.
REQ-013 SHALL have port tl_a_mask  input  DataWidth/8  byte enables.
REQ-014 SHALL have port tl_a_data  input  DataWidth  write data.
REQ-015 SHALL have port tl_d_valid  output  1  D response valid.
REQ-016 SHALL have port tl_d_ready  input  1  D response accepted.
REQ-017 SHALL have port tl_d_opcode  output  3  0=AccessAck, 1=AccessAckData.
REQ-018 SHALL have port tl_d_source  output  SourceWidth  echoed A source.
REQ-019 SHALL have port tl_d_error  output  1  response error.
REQ-020 SHALL have port axi_awaddr / axi_awsize / axi_awvalid  output  AddrWidth / 3 / 1, plus axi_awready  input  1  AXI write address channel; ID fixed 0, single-beat INCR.
REQ-021 SHALL have port axi_wdata / axi_wstrb / axi_wvalid  output  DataWidth / DataWidth/8 / 1, plus axi_wready  input  1  AXI write data channel; single beat.
REQ-022 SHALL have port axi_bresp  input  2, axi_bvalid  input  1, axi_bready  output  1  AXI write response channel.

Function
REQ-023 SHALL assert tl_a_ready only when the tracking FIFO is not full and the issue holding register is empty; a pop in the same cycle SHALL NOT free a full FIFO for a push.
REQ-024 SHALL, on an accepted Put, load addr/size/mask/data into the holding register and push {source, local=0} into the tracking FIFO.
REQ-025 SHALL, on an accepted unsupported opcode or Get, push {source, local=1, opcode} and issue no AXI traffic.
REQ-026 SHALL raise axi_awvalid and axi_wvalid together in the cycle after acceptance, drop each independently after its own handshake, and free the holding register once both have completed.
REQ-027 SHALL drive awsize = tl_a_size, wstrb = tl_a_mask, and wdata = tl_a_data, all from the holding register, stable while valid.
REQ-028 SHALL serve D strictly in FIFO order: a local head gives tl_d_valid=1, error=1, opcode 1 for Get and 0 otherwise.
REQ-029 SHALL, for a non-local head, set tl_d_valid = axi_bvalid, axi_bready = tl_d_ready, opcode = 0, and tl_d_error = axi_bresp[1] (SLVERR/DECERR).
REQ-030 SHALL hold axi_bready=0 while the FIFO is empty or the head is local.
REQ-031 SHALL pop on tl_d_valid & tl_d_ready; FIFO pointers wrap modulo Depth, and push plus pop in one cycle keeps occupancy.
REQ-032 SHALL hold D outputs stable while tl_d_valid=1 and tl_d_ready=0.

Reset
REQ-033 SHALL, while rst_i=1, force all outputs to 0, empty the FIFO and holding register, and discard in-flight transactions; tl_a_ready SHALL rise in the first cycle after rst_i falls.

Configuration
REQ-034 SHALL, with TLUL_AXI4_ALIGN_CHK_EN defined, treat a Put whose address is not aligned to 2^size, or whose size > log2(DataWidth/8), as local (error response, no AXI); without it, such Puts SHALL be forwarded unchanged.

Verification
REQ-035 Put (opcode 0, addr 0x100, size 3, src 0x12) with awready and wready high -> AW/W one cycle each; bresp=0 -> D opcode 0, src 0x12, error 0.
REQ-036 awready low 5 cycles, wready high -> W completes first, AW held with stable addr, tl_a_ready low until AW completes.
REQ-037 Four Puts with bvalid low -> tl_a_ready low after the 4th; one D pop plus a new A in the same cycle -> A not accepted that cycle.
REQ-038 Put src 1, Get src 2, Put src 3, then bresp 0 then 2 -> D order src 1 (err 0), src 2 (opcode 1, err 1), src 3 (err 1).
REQ-039 Put addr 0x104, size 3 -> with the macro: local error, no awvalid; without the macro: AW issued with addr 0x104.
REQ-040 rst_i pulsed while AW is pending -> awvalid and tl_d_valid are 0 the next cycle, and tl_a_ready=1 the cycle after rst_i falls.

Source files
------------

// File: rtl/tlul_to_axi4_wr_if.sv
// Bundle of the TL-UL A/D channels and the AXI4 write channels (AW, W, B)
// seen by the TL-UL to AXI4 write bridge.
// The slave modport is the bridge's view. The master modport is the view of
// the surrounding system: the TL-UL host plus the AXI4 write slave.
interface tlul_to_axi4_wr_if #(
  parameter int DataWidth   = 64,
  parameter int AddrWidth   = 32,
  parameter int SourceWidth = 8
);
  localparam int StrbWidth = DataWidth / 8;

  // TL-UL A channel
  logic                   tl_a_valid;
  logic                   tl_a_ready;
  logic [2:0]             tl_a_opcode;
  logic [2:0]             tl_a_size;
  logic [SourceWidth-1:0] tl_a_source;
  logic [AddrWidth-1:0]   tl_a_address;
  logic [StrbWidth-1:0]   tl_a_mask;
  logic [DataWidth-1:0]   tl_a_data;

  // TL-UL D channel
  logic                   tl_d_valid;
  logic                   tl_d_ready;
  logic [2:0]             tl_d_opcode;
  logic [SourceWidth-1:0] tl_d_source;
  logic                   tl_d_error;

  // AXI4 write address channel
  // ID is implicitly 0 and every burst is a single INCR beat.
  logic [AddrWidth-1:0]   axi_awaddr;
  logic [2:0]             axi_awsize;
  logic                   axi_awvalid;
  logic                   axi_awready;

  // AXI4 write data channel (single beat)
  logic [DataWidth-1:0]   axi_wdata;
  logic [StrbWidth-1:0]   axi_wstrb;
  logic                   axi_wvalid;
  logic                   axi_wready;

  // AXI4 write response channel
  logic [1:0]             axi_bresp;
  logic                   axi_bvalid;
  logic                   axi_bready;

  modport slave (
    input  tl_a_valid, tl_a_opcode, tl_a_size, tl_a_source, tl_a_address,
           tl_a_mask, tl_a_data,
    output tl_a_ready,
    output tl_d_valid, tl_d_opcode, tl_d_source, tl_d_error,
    input  tl_d_ready,
    output axi_awaddr, axi_awsize, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready
  );

  modport master (
    output tl_a_valid, tl_a_opcode, tl_a_size, tl_a_source, tl_a_address,
           tl_a_mask, tl_a_data,
    input  tl_a_ready,
    input  tl_d_valid, tl_d_opcode, tl_d_source, tl_d_error,
    output tl_d_ready,
    input  axi_awaddr, axi_awsize, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready
  );
endinterface

// File: rtl/tlul_to_axi4_wr.sv
// TL-UL to AXI4 write bridge.
//
// An accepted Put is parked in a one-entry holding register. It is issued
// as a single-beat AXI write, with AW and W raised together and retired
// independently. Every accepted A request, forwarded or not, gets an entry
// in an in-order tracking FIFO. Gets and unsupported opcodes become "local"
// entries that are answered with an error directly from the FIFO head,
// without touching AXI. Because AXI B responses come back in order (single
// ID), the oldest non-local FIFO entry always owns the next B beat.
//
// Optional feature: define TLUL_AXI4_ALIGN_CHK_EN to make a Put local (error
// response, no AXI traffic) when its address is not aligned to 2^size or
// when its size exceeds the bus width. Without the macro such Puts are
// forwarded unchanged.
module tlul_to_axi4_wr #(
  parameter int DataWidth   = 64,
  parameter int AddrWidth   = 32,
  parameter int SourceWidth = 8,
  parameter int Depth       = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  tlul_to_axi4_wr_if.slave       bus
);
  localparam int StrbWidth = DataWidth / 8;
  localparam int PtrWidth  = $clog2(Depth);
  localparam int SizeMax   = $clog2(StrbWidth);

  localparam logic [2:0] OpPutFull     = 3'd0;
  localparam logic [2:0] OpPutPartial  = 3'd1;
  localparam logic [2:0] OpGet         = 3'd4;
  localparam logic [2:0] OpAccessAck   = 3'd0;
  localparam logic [2:0] OpAccessAckD  = 3'd1;

  localparam logic [PtrWidth-1:0] PtrOne  = PtrWidth'(1);
  localparam logic [PtrWidth:0]   CntOne  = (PtrWidth + 1)'(1);
  localparam logic [PtrWidth:0]   CntFull = (PtrWidth + 1)'(Depth);

  // Issue FSM: which of AW / W are still owed for the held Put.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BOTH,
    ST_AW_ONLY,
    ST_W_ONLY
  } issue_state_e;

  issue_state_e r_state;
  issue_state_e w_state_next;

  // Holding register
  logic [AddrWidth-1:0] r_hold_addr;
  logic [2:0]           r_hold_size;
  logic [StrbWidth-1:0] r_hold_mask;
  logic [DataWidth-1:0] r_hold_data;

  // Tracking FIFO
  logic [SourceWidth-1:0] r_fifo_src [Depth];
  logic [Depth-1:0]       r_fifo_local;
  logic [Depth-1:0]       r_fifo_get;
  logic [PtrWidth-1:0]    r_wr_ptr;
  logic [PtrWidth-1:0]    r_rd_ptr;
  logic [PtrWidth:0]      r_count;
  logic [Depth-1:0]       w_entry_we;

  // A-side decode
  logic w_is_put;
  logic w_is_get;
  logic w_misaligned;
  logic w_fwd;
  logic w_full;
  logic w_empty;
  logic w_a_ready;
  logic w_accept;
  logic w_push;
  logic w_pop;

  // AXI issue
  logic w_awvalid;
  logic w_wvalid;
  logic w_aw_hs;
  logic w_w_hs;

  // D side
  logic                   w_head_local;
  logic                   w_head_get;
  logic [SourceWidth-1:0] w_head_src;
  logic                   w_d_valid;
  logic [2:0]             w_d_opcode;
  logic [SourceWidth-1:0] w_d_source;
  logic                   w_d_error;
  logic                   w_b_ready;

  // Only the error bit of BRESP matters: OKAY and EXOKAY both mean success.
  logic w_unused_bresp0;
  assign w_unused_bresp0 = bus.axi_bresp[0];

  // ------------------------------------------------------------------
  // A channel acceptance
  // ------------------------------------------------------------------
  assign w_is_put = (bus.tl_a_opcode == OpPutFull) || (bus.tl_a_opcode == OpPutPartial);
  assign w_is_get = (bus.tl_a_opcode == OpGet);

`ifdef TLUL_AXI4_ALIGN_CHK_EN
  logic [AddrWidth-1:0] w_align_mask;
  assign w_align_mask = (AddrWidth'(1) << bus.tl_a_size) - AddrWidth'(1);
  assign w_misaligned = (|(bus.tl_a_address & w_align_mask)) ||
                        (bus.tl_a_size > 3'(SizeMax));
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_fwd   = w_is_put && !w_misaligned;
  assign w_full  = (r_count == CntFull);
  assign w_empty = (r_count == '0);

  // Ready depends only on registered state, so a D pop in this same cycle
  // never makes room for a push into a full FIFO.
  assign w_a_ready = !rst_i && !w_full && (r_state == ST_IDLE);
  assign w_accept  = bus.tl_a_valid && w_a_ready;
  assign w_push    = w_accept;

  // ------------------------------------------------------------------
  // Holding register and issue FSM
  // ------------------------------------------------------------------
  // Capture the AXI payload of a forwarded Put; it stays put until both
  // AW and W have handshaken, keeping the channels stable while valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold_addr <= '0;
      r_hold_size <= '0;
      r_hold_mask <= '0;
      r_hold_data <= '0;
    end else if (w_accept && w_fwd) begin
      r_hold_addr <= bus.tl_a_address;
      r_hold_size <= bus.tl_a_size;
      r_hold_mask <= bus.tl_a_mask;
      r_hold_data <= bus.tl_a_data;
    end
  end

  // Issue state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_aw_hs = w_awvalid && bus.axi_awready;
  assign w_w_hs  = w_wvalid && bus.axi_wready;

  // Next issue state and AW/W valids; each channel drops on its own handshake.
  always_comb begin
    w_state_next = r_state;
    w_awvalid    = 1'b0;
    w_wvalid     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept && w_fwd) begin
          w_state_next = ST_BOTH;
        end
      end
      ST_BOTH: begin
        w_awvalid = !rst_i;
        w_wvalid  = !rst_i;
        if (w_aw_hs && w_w_hs) begin
          w_state_next = ST_IDLE;
        end else if (w_aw_hs) begin
          w_state_next = ST_W_ONLY;
        end else if (w_w_hs) begin
          w_state_next = ST_AW_ONLY;
        end
      end
      ST_AW_ONLY: begin
        w_awvalid = !rst_i;
        if (w_aw_hs) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_W_ONLY: begin
        w_wvalid = !rst_i;
        if (w_w_hs) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Tracking FIFO
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < Depth; gi++) begin : g_entry_we
      assign w_entry_we[gi] = w_push && (r_wr_ptr == PtrWidth'(gi));
    end
  endgenerate

  // Entry payload: source, local flag and whether a local entry was a Get.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Depth; i++) begin
      if (w_entry_we[i]) begin
        r_fifo_src[i]   <= bus.tl_a_source;
        r_fifo_local[i] <= !w_fwd;
        r_fifo_get[i]   <= w_is_get;
      end
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // D channel
  // ------------------------------------------------------------------
  assign w_head_local = r_fifo_local[r_rd_ptr];
  assign w_head_get   = r_fifo_get[r_rd_ptr];
  assign w_head_src   = r_fifo_src[r_rd_ptr];

  // Local heads answer immediately with an error; forwarded heads pass the
  // B beat straight through, so D stability follows the AXI slave's B hold.
  always_comb begin
    w_d_valid  = 1'b0;
    w_d_opcode = OpAccessAck;
    w_d_source = '0;
    w_d_error  = 1'b0;
    w_b_ready  = 1'b0;
    if (!rst_i && !w_empty) begin
      w_d_source = w_head_src;
      if (w_head_local) begin
        w_d_valid  = 1'b1;
        w_d_error  = 1'b1;
        w_d_opcode = w_head_get ? OpAccessAckD : OpAccessAck;
      end else begin
        w_d_valid  = bus.axi_bvalid;
        w_d_error  = bus.axi_bresp[1];
        w_b_ready  = bus.tl_d_ready;
      end
    end
  end

  assign w_pop = w_d_valid && bus.tl_d_ready;

  // ------------------------------------------------------------------
  // Outputs (all forced low while reset is held)
  // ------------------------------------------------------------------
  assign bus.tl_a_ready  = w_a_ready;
  assign bus.tl_d_valid  = w_d_valid;
  assign bus.tl_d_opcode = w_d_opcode;
  assign bus.tl_d_source = w_d_source;
  assign bus.tl_d_error  = w_d_error;

  assign bus.axi_awvalid = w_awvalid;
  assign bus.axi_awaddr  = rst_i ? '0 : r_hold_addr;
  assign bus.axi_awsize  = rst_i ? '0 : r_hold_size;
  assign bus.axi_wvalid  = w_wvalid;
  assign bus.axi_wdata   = rst_i ? '0 : r_hold_data;
  assign bus.axi_wstrb   = rst_i ? '0 : r_hold_mask;
  assign bus.axi_bready  = w_b_ready;

endmodule

// File: tb/tb_tlul_to_axi4_wr.sv
// Bench for tlul_to_axi4_wr: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based transaction model.
module tb_tlul_to_axi4_wr;
  localparam int DW       = 64;
  localparam int AW       = 32;
  localparam int SW       = 8;
  localparam int DEPTH    = 4;
  localparam int SB       = DW / 8;
  localparam int SIZE_MAX = $clog2(SB);
`ifdef TLUL_AXI4_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tlul_to_axi4_wr_if #(.DataWidth(DW), .AddrWidth(AW), .SourceWidth(SW)) bus ();

  tlul_to_axi4_wr #(
    .DataWidth(DW), .AddrWidth(AW), .SourceWidth(SW), .Depth(DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct { logic [SW-1:0] src; bit lcl; bit get; } d_exp_t;
  typedef struct { logic [AW-1:0] addr; logic [2:0] size; } aw_exp_t;
  typedef struct { logic [DW-1:0] data; logic [SB-1:0] strb; } w_exp_t;
  typedef struct { logic [2:0] op; logic [2:0] size; logic [AW-1:0] addr; logic [SW-1:0] src; } a_req_t;

  d_exp_t  dq[$];
  aw_exp_t awq[$];
  w_exp_t  wq[$];
  a_req_t  a_force[$];
  int      b_force[$];

  int n_checks = 0;
  int n_fail   = 0;
  int p_av, p_awr, p_wr, p_dr, p_bv;
  bit a_hold, b_hold;
  int aw_cnt, w_cnt, b_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // Reference rule: which A requests are answered locally instead of via AXI.
  function automatic bit expect_local(input logic [2:0] op, input logic [2:0] size,
                                      input logic [AW-1:0] addr);
    bit non_put;
    bit bad_align;
    non_put   = !(op == 3'd0 || op == 3'd1);
    bad_align = (int'(size) > SIZE_MAX) || ((addr % (AW'(1) << size)) != 0);
    return non_put || (ALIGN_CHK && bad_align);
  endfunction

  function automatic a_req_t rand_req();
    a_req_t r;
    int k;
    k = int'($urandom_range(9));
    if (k < 4)      r.op = 3'd0;
    else if (k < 7) r.op = 3'd1;
    else if (k < 8) r.op = 3'd4;
    else            r.op = 3'($urandom_range(7));
    r.size = pct(90) ? 3'($urandom_range(3)) : 3'($urandom_range(7));
    r.addr = AW'($urandom);
    if (pct(80)) r.addr = r.addr & ~((AW'(1) << r.size) - AW'(1));
    r.src = SW'($urandom);
    return r;
  endfunction

  task automatic queue_req(input logic [2:0] op, input logic [2:0] size,
                           input logic [AW-1:0] addr, input logic [SW-1:0] src);
    a_req_t r;
    r.op = op; r.size = size; r.addr = addr; r.src = src;
    a_force.push_back(r);
  endtask

  task automatic set_knobs(input int av, input int awr, input int wr, input int dr, input int bv);
    p_av = av; p_awr = awr; p_wr = wr; p_dr = dr; p_bv = bv;
  endtask

  // Drive all DUT inputs for the coming cycle (A and B held until accepted).
  task automatic drive_inputs();
    a_req_t r;
    bit go;
    int avail;
    go = 1'b0;
    if (!a_hold) begin
      if (a_force.size() > 0) begin
        r = a_force.pop_front();
        go = 1'b1;
      end else if (pct(p_av)) begin
        r = rand_req();
        go = 1'b1;
      end
      if (go) begin
        bus.tl_a_valid   = 1'b1;
        bus.tl_a_opcode  = r.op;
        bus.tl_a_size    = r.size;
        bus.tl_a_address = r.addr;
        bus.tl_a_source  = r.src;
        bus.tl_a_mask    = SB'($urandom);
        bus.tl_a_data    = DW'({$urandom(), $urandom()});
        a_hold = 1'b1;
      end else begin
        bus.tl_a_valid = 1'b0;
      end
    end
    bus.axi_awready = pct(p_awr);
    bus.axi_wready  = pct(p_wr);
    bus.tl_d_ready  = pct(p_dr);
    if (!b_hold) begin
      avail = ((aw_cnt < w_cnt) ? aw_cnt : w_cnt) - b_cnt;
      if (avail > 0 && (b_force.size() > 0 || pct(p_bv))) begin
        bus.axi_bvalid = 1'b1;
        bus.axi_bresp  = (b_force.size() > 0) ? 2'(b_force.pop_front()) : 2'($urandom_range(3));
        b_hold = 1'b1;
      end else begin
        bus.axi_bvalid = 1'b0;
      end
    end
  endtask

  // Compare every DUT output against what the model says this cycle must show.
  task automatic check_cycle();
    bit exp_ardy, exp_dv, exp_br;
    exp_ardy = (dq.size() < DEPTH) && (awq.size() == 0) && (wq.size() == 0);
    check_eq("a_ready", 64'(bus.tl_a_ready), 64'(exp_ardy));
    check_eq("awvalid", 64'(bus.axi_awvalid), 64'(awq.size() != 0));
    check_eq("wvalid", 64'(bus.axi_wvalid), 64'(wq.size() != 0));
    if (bus.axi_awvalid && awq.size() != 0) begin
      check_eq("awaddr", 64'(bus.axi_awaddr), 64'(awq[0].addr));
      check_eq("awsize", 64'(bus.axi_awsize), 64'(awq[0].size));
    end
    if (bus.axi_wvalid && wq.size() != 0) begin
      check_eq("wdata", 64'(bus.axi_wdata), 64'(wq[0].data));
      check_eq("wstrb", 64'(bus.axi_wstrb), 64'(wq[0].strb));
    end
    if (dq.size() == 0) begin
      exp_dv = 1'b0; exp_br = 1'b0;
    end else if (dq[0].lcl) begin
      exp_dv = 1'b1; exp_br = 1'b0;
    end else begin
      exp_dv = bus.axi_bvalid; exp_br = bus.tl_d_ready;
    end
    check_eq("d_valid", 64'(bus.tl_d_valid), 64'(exp_dv));
    check_eq("bready", 64'(bus.axi_bready), 64'(exp_br));
    if (exp_dv && bus.tl_d_valid) begin
      check_eq("d_source", 64'(bus.tl_d_source), 64'(dq[0].src));
      check_eq("d_opcode", 64'(bus.tl_d_opcode), 64'((dq[0].lcl && dq[0].get) ? 1 : 0));
      check_eq("d_error", 64'(bus.tl_d_error), 64'(dq[0].lcl ? 1'b1 : bus.axi_bresp[1]));
    end
  endtask

  // Advance the model by the handshakes that complete at the next edge.
  task automatic update_model();
    d_exp_t  e;
    aw_exp_t a;
    w_exp_t  w;
    if (bus.tl_a_valid && bus.tl_a_ready) begin
      e.src = bus.tl_a_source;
      e.lcl = expect_local(bus.tl_a_opcode, bus.tl_a_size, bus.tl_a_address);
      e.get = (bus.tl_a_opcode == 3'd4);
      dq.push_back(e);
      if (!e.lcl) begin
        a.addr = bus.tl_a_address; a.size = bus.tl_a_size;
        w.data = bus.tl_a_data;    w.strb = bus.tl_a_mask;
        awq.push_back(a);
        wq.push_back(w);
      end
      a_hold = 1'b0;
      $display("A op=%0d size=%0d addr=0x%08h src=0x%02h route=%s",
               bus.tl_a_opcode, bus.tl_a_size, bus.tl_a_address, bus.tl_a_source,
               e.lcl ? "local" : "axi");
    end
    if (bus.axi_awvalid && bus.axi_awready) begin
      if (awq.size() != 0) awq.delete(0);
      aw_cnt++;
    end
    if (bus.axi_wvalid && bus.axi_wready) begin
      if (wq.size() != 0) wq.delete(0);
      w_cnt++;
    end
    if (bus.axi_bvalid && bus.axi_bready) begin
      b_cnt++;
      b_hold = 1'b0;
    end
    if (bus.tl_d_valid && bus.tl_d_ready) begin
      $display("D src=0x%02h opcode=%0d error=%0d",
               bus.tl_d_source, bus.tl_d_opcode, bus.tl_d_error);
      if (dq.size() != 0) dq.delete(0);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_inputs();
      @(negedge clk);
      check_cycle();
      update_model();
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse reset for one cycle, check outputs during and right after it.
  task automatic apply_reset();
    rst = 1'b1;
    bus.tl_a_valid  = 1'b0;
    bus.axi_awready = 1'b0;
    bus.axi_wready  = 1'b0;
    bus.axi_bvalid  = 1'b0;
    bus.tl_d_ready  = 1'b0;
    @(negedge clk);
    check_eq("rst_a_ready", 64'(bus.tl_a_ready), 64'd0);
    check_eq("rst_awvalid", 64'(bus.axi_awvalid), 64'd0);
    check_eq("rst_wvalid", 64'(bus.axi_wvalid), 64'd0);
    check_eq("rst_d_valid", 64'(bus.tl_d_valid), 64'd0);
    check_eq("rst_bready", 64'(bus.axi_bready), 64'd0);
    dq.delete(); awq.delete(); wq.delete();
    a_hold = 1'b0; b_hold = 1'b0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_a_ready", 64'(bus.tl_a_ready), 64'd1);
    check_eq("post_rst_awvalid", 64'(bus.axi_awvalid), 64'd0);
    check_eq("post_rst_d_valid", 64'(bus.tl_d_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    rst = 1'b1;
    bus.tl_a_valid = 1'b0; bus.tl_a_opcode = '0; bus.tl_a_size = '0;
    bus.tl_a_address = '0; bus.tl_a_source = '0; bus.tl_a_mask = '0; bus.tl_a_data = '0;
    bus.tl_d_ready = 1'b0; bus.axi_awready = 1'b0; bus.axi_wready = 1'b0;
    bus.axi_bvalid = 1'b0; bus.axi_bresp = '0;
    a_hold = 1'b0; b_hold = 1'b0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    set_knobs(0, 100, 100, 100, 100);
    @(posedge clk);
    #1;
    apply_reset();

    // Basic Put, OKAY response.
    queue_req(3'd0, 3'd3, 32'h100, 8'h12);
    b_force.push_back(0);
    run(8);

    // AW stalled for several cycles while W goes through.
    set_knobs(0, 0, 100, 100, 100);
    queue_req(3'd1, 3'd2, 32'h208, 8'h21);
    run(6);
    set_knobs(0, 100, 100, 100, 100);
    run(6);

    // Fill the FIFO with B held off, then release with pops racing new A's.
    set_knobs(0, 100, 100, 100, 0);
    for (int i = 0; i < 6; i++) queue_req(3'd0, 3'd3, AW'(32'h400 + 8 * i), SW'(8'h30 + i));
    run(14);
    set_knobs(0, 100, 100, 100, 100);
    run(20);

    // Mixed ordering: Put / Get / Put with OKAY then SLVERR.
    queue_req(3'd0, 3'd3, 32'h500, 8'h01);
    queue_req(3'd4, 3'd3, 32'h508, 8'h02);
    queue_req(3'd0, 3'd3, 32'h510, 8'h03);
    b_force.push_back(0);
    b_force.push_back(2);
    run(12);

    // Misaligned Put and unsupported opcodes.
    queue_req(3'd0, 3'd3, 32'h104, 8'h44);
    queue_req(3'd6, 3'd2, 32'h600, 8'h45);
    queue_req(3'd0, 3'd5, 32'h700, 8'h46);
    run(12);

    // Randomized phases with increasing back-pressure.
    set_knobs(70, 60, 60, 70, 60);
    run(400);
    set_knobs(80, 90, 90, 30, 40);
    run(400);
    set_knobs(70, 20, 80, 80, 80);
    run(300);

    // Reset while an AW is stuck pending.
    set_knobs(100, 0, 0, 100, 100);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      run(1);
      found = (awq.size() != 0);
    end
    run(1);
    check_eq("aw_pending_before_rst", 64'(found), 64'd1);
    apply_reset();

    // Traffic after reset, then drain.
    set_knobs(60, 80, 80, 80, 80);
    run(200);
    set_knobs(0, 100, 100, 100, 100);
    for (int i = 0; i < 200 && (dq.size() != 0 || a_hold); i++) run(1);
    check_eq("drain_empty", 64'(dq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
